// File: rtl/reg_resp_fsm.sv
// Register-access response framer: queues write-ack / read-response frames
// and streams each one to a byte-wide UART transmitter as status, address, data.
module reg_resp_fsm #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  CODE_WR_ACK = 8'h81,
  parameter logic [7:0]  CODE_RD_RSP = 8'h82
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_ack_i,
  input  logic       rd_valid_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] rd_data_i,
  input  logic       clr_ovf_i,
  input  logic       tx_done_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       busy_o,
  output logic       full_o,
  output logic       ovf_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STAT, S_ADDR, S_DATA} state_e;

  state_e      state_q;
  logic [23:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic [7:0]  addr_q, data_q, tx_data_q;
  logic        tx_start_q, ovf_q;

  logic        push_req, pop, full, push_ok, ovf_set;
  logic [23:0] entry_d;

  assign push_req = wr_ack_i | rd_valid_i;
  assign full     = (cnt_q == CNT_MAX);
  // Popping only happens from idle, so a slot frees up in the same cycle.
  assign pop      = (state_q == S_IDLE) && (cnt_q != '0);
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = (wr_ack_i && rd_valid_i) || (push_req && full && !pop);
  assign entry_d  = rd_valid_i ? {CODE_RD_RSP, addr_i, rd_data_i}
                               : {CODE_WR_ACK, addr_i, 8'h00};

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= entry_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
      if (push_ok && !pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (!push_ok && pop) cnt_q <= cnt_q - CNT_ONE;
      if (ovf_set)        ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  // tx_done_i is ignored while tx_start_q is high: the byte was only just loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (pop) begin
          {tx_data_q, addr_q, data_q} <= mem_q[rptr_q];
          tx_start_q <= 1'b1;
          state_q    <= S_STAT;
        end
        S_STAT: if (tx_done_i && !tx_start_q) begin
          tx_data_q  <= addr_q;
          tx_start_q <= 1'b1;
          state_q    <= S_ADDR;
        end
        S_ADDR: if (tx_done_i && !tx_start_q) begin
          tx_data_q  <= data_q;
          tx_start_q <= 1'b1;
          state_q    <= S_DATA;
        end
        S_DATA: if (tx_done_i && !tx_start_q) begin
          tx_data_q <= 8'h00;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q != S_IDLE) || (cnt_q != '0);
  assign full_o     = full;
  assign ovf_o      = ovf_q;
endmodule

// File: tb/tb_reg_resp_fsm.sv
// Randomized + directed bench for reg_resp_fsm against a frame-queue reference model.
module tb_reg_resp_fsm;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_ack_i = 0, rd_valid_i = 0, clr_ovf_i = 0, tx_done_i = 0;
  logic [7:0] addr_i = 0, rd_data_i = 0;
  logic       tx_start_o, busy_o, full_o, ovf_o;
  logic [7:0] tx_data_o;

  int nvec = 0, nerr = 0;

  reg_resp_fsm #(.FIFO_DEPTH(DEPTH), .CODE_WR_ACK(8'h81), .CODE_RD_RSP(8'h82)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ack_i(wr_ack_i), .rd_valid_i(rd_valid_i),
    .addr_i(addr_i), .rd_data_i(rd_data_i), .clr_ovf_i(clr_ovf_i), .tx_done_i(tx_done_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .busy_o(busy_o),
    .full_o(full_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Reference: pending frames queue, current frame, byte index (0 = no frame), start flag.
  logic [23:0] mq[$];
  logic [23:0] m_frame;
  int          m_idx;
  bit          m_first, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_byte();
    case (m_idx)
      1: return m_frame[23:16];
      2: return m_frame[15:8];
      3: return m_frame[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_frame = '0; m_idx = 0; m_first = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit req, pop;
    logic [23:0] f;
    req = wr_ack_i || rd_valid_i;
    pop = (m_idx == 0) && (mq.size() > 0);
    if ((wr_ack_i && rd_valid_i) || (req && mq.size() == DEPTH && !pop)) m_ovf = 1;
    else if (clr_ovf_i) m_ovf = 0;
    f = '0;
    if (pop) f = mq.pop_front();
    if (req && mq.size() < DEPTH)
      mq.push_back(rd_valid_i ? {8'h82, addr_i, rd_data_i} : {8'h81, addr_i, 8'h00});
    if (pop) begin
      m_frame = f; m_idx = 1; m_first = 1;
    end else if (m_idx != 0 && !m_first && tx_done_i) begin
      m_idx   = (m_idx == 3) ? 0 : m_idx + 1;
      m_first = (m_idx != 0);
    end else m_first = 0;
  endtask

  task automatic compare_all();
    chk("tx_start", 32'(tx_start_o), 32'(m_first));
    chk("tx_data",  32'(tx_data_o),  32'(m_byte()));
    chk("busy",     32'(busy_o),     32'((m_idx != 0) || (mq.size() != 0)));
    chk("full",     32'(full_o),     32'(mq.size() == DEPTH));
    chk("ovf",      32'(ovf_o),      32'(m_ovf));
  endtask

  // One clock cycle: inputs held for the cycle, outputs checked at the following negedge.
  task automatic cyc(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d,
                     input bit done, input bit clr);
    wr_ack_i = wr; rd_valid_i = rd; addr_i = a; rd_data_i = d;
    tx_done_i = done; clr_ovf_i = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    wr_ack_i = 0; rd_valid_i = 0; tx_done_i = 0; clr_ovf_i = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    wr_ack_i = 0; rd_valid_i = 0; tx_done_i = 0; clr_ovf_i = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_start", 32'(tx_start_o), 0);
    chk("rst_data",  32'(tx_data_o),  0);
    chk("rst_busy",  32'(busy_o),     0);
    chk("rst_full",  32'(full_o),     0);
    chk("rst_ovf",   32'(ovf_o),      0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Frame already started (at a start-cycle negedge): finish it with done 10 cycles after each start.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp [3];
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    for (int k = 0; k < 3; k++) begin
      chk("frame_start", 32'(tx_start_o), 1);
      chk("frame_byte",  32'(tx_data_o),  32'(exp[k]));
      idle(10);
      cyc(0, 0, 8'h00, 8'h00, 1, 0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Read response with two-cycle latency.
    cyc(0, 1, 8'h10, 8'hA5, 0, 0);
    chk("lat_n1", 32'(tx_start_o), 0);
    idle(1);
    send_frame(8'h82, 8'h10, 8'hA5);
    chk("busy_after", 32'(busy_o), 0);

    // Write ack.
    cyc(1, 0, 8'h03, 8'hFF, 0, 0);
    idle(1);
    send_frame(8'h81, 8'h03, 8'h00);

    // Six back-to-back reads with transmitter stalled.
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'h20 + i), 8'(8'h50 + i), 0, 0);
    chk("burst_full", 32'(full_o), 1);
    chk("burst_ovf",  32'(ovf_o),  1);
    for (int i = 0; i < 80; i++) cyc(0, 0, 8'h00, 8'h00, (i % 3) == 2, 0);
    chk("burst_drained", 32'(busy_o), 0);
    cyc(0, 0, 8'h00, 8'h00, 0, 1);

    // Simultaneous read and write ack, then clear.
    cyc(1, 1, 8'h44, 8'h99, 0, 0);
    chk("both_ovf", 32'(ovf_o), 1);
    idle(1);
    send_frame(8'h82, 8'h44, 8'h99);
    chk("both_single", 32'(busy_o), 0);
    cyc(0, 0, 8'h00, 8'h00, 0, 1);
    chk("clr_ovf", 32'(ovf_o), 0);

    // Reset after address byte start.
    cyc(0, 1, 8'h77, 8'h66, 0, 0);
    idle(2);
    cyc(0, 0, 8'h00, 8'h00, 1, 0);
    chk("addr_start", 32'(tx_data_o), 32'h77);
    do_reset();
    idle(20);

    // tx_done in idle and in a start cycle.
    cyc(0, 0, 8'h00, 8'h00, 1, 0);
    cyc(1, 0, 8'h05, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 8'h00, 1, 0);
    chk("start_done_ign", 32'(tx_data_o), 32'h81);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit wr, rd;
      r  = $urandom_range(0, 99);
      wr = (r < 12) || (r >= 97);
      rd = (r >= 12 && r < 24) || (r >= 97);
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
        compare_all();
      end else
        cyc(wr, rd, 8'($urandom), 8'($urandom), $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/reg_resp_fsm.md
REG_RESP_FSM -- requirements
Module: reg_resp_fsm

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of queued response frames; power of two, >= 2.
REQ-002 SHALL have parameter CODE_WR_ACK, default 8'h81, status byte of a write-acknowledge frame.
REQ-003 SHALL have parameter CODE_RD_RSP, default 8'h82, status byte of a read-response frame.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_ack_i  input  1  one-cycle pulse: register write completed at addr_i.
REQ-007 SHALL have port rd_valid_i  input  1  one-cycle pulse: rd_data_i holds the register read at addr_i.
REQ-008 SHALL have port addr_i  input  8  register address qualified by wr_ack_i or rd_valid_i.
REQ-009 SHALL have port rd_data_i  input  8  read data qualified by rd_valid_i.
REQ-010 SHALL have port clr_ovf_i  input  1  synchronous clear of ovf_o.
REQ-011 SHALL have port tx_done_i  input  1  one-cycle pulse from the UART transmitter: current byte sent.
REQ-012 SHALL have port tx_start_o  output  1  one-cycle pulse: transmitter loads tx_data_o.
REQ-013 SHALL have port tx_data_o  output  8  byte to transmit.
REQ-014 SHALL have port busy_o  output  1  frame in progress or FIFO non-empty.
REQ-015 SHALL have port full_o  output  1  FIFO holds FIFO_DEPTH entries.
REQ-016 SHALL have port ovf_o  output  1  sticky: a request was dropped.

Function
REQ-017 SHALL send each frame as 3 bytes in order: status, address, data; data = rd_data_i for reads, 8'h00 for write acks.
REQ-018 SHALL push {status, addr, data} into the FIFO on the clock edge ending the cycle in which wr_ack_i or rd_valid_i is high.
REQ-019 SHALL, when rd_valid_i and wr_ack_i are high together, push the read frame only, drop the write ack, and set ovf_o.
REQ-020 SHALL, on a push while full_o=1 with no pop in that cycle, drop the request, keep FIFO content, and set ovf_o.
REQ-021 SHALL accept a push while full if a pop occurs in the same cycle; the count stays FIFO_DEPTH.
REQ-022 SHALL implement FIFO read/write pointers with natural wrap-around modulo FIFO_DEPTH and an occupancy count of clog2(FIFO_DEPTH)+1 bits.
REQ-023 SHALL implement states S_IDLE, S_STAT, S_ADDR, S_DATA.
REQ-024 SHALL, in S_IDLE with FIFO non-empty, pop one entry into frame registers and go to S_STAT.
REQ-025 SHALL assert tx_start_o for exactly the first cycle in each of S_STAT, S_ADDR, S_DATA, and at no other time.
REQ-026 SHALL drive tx_data_o with the byte of the current state from the tx_start_o cycle until leaving that state.
REQ-027 SHALL move S_STAT->S_ADDR, S_ADDR->S_DATA, S_DATA->S_IDLE on tx_done_i, ignoring tx_done_i in the tx_start_o cycle and in S_IDLE.
REQ-028 SHALL give latency: request in cycle N with FIFO empty and S_IDLE -> tx_start_o high in cycle N+2 with status byte.
REQ-029 SHALL, after tx_done_i in S_DATA at cycle M with FIFO non-empty, assert tx_start_o of the next frame in cycle M+2.
REQ-030 SHALL drive busy_o = (state != S_IDLE) or FIFO non-empty, full_o = (count == FIFO_DEPTH), both combinational from registers.
REQ-031 SHALL clear ovf_o on clr_ovf_i; a set event in the same cycle takes priority and ovf_o stays 1.
REQ-032 SHALL keep tx_data_o at 8'h00 in S_IDLE.

Reset
REQ-033 SHALL, while rst_n=0, force state S_IDLE, FIFO empty, pointers 0, tx_start_o=0, tx_data_o=8'h00, busy_o=0, full_o=0, ovf_o=0.
REQ-034 SHALL abandon any partially sent frame and all queued entries on reset; no tx_start_o after release until a new request.

Verification
REQ-035 SHALL pass: rd_valid_i, addr_i=8'h10, rd_data_i=8'hA5, tx_done_i 10 cycles after each start -> tx_start_o at N+2, bytes 8'h82, 8'h10, 8'hA5, then busy_o=0.
REQ-036 SHALL pass: wr_ack_i with addr_i=8'h03 -> bytes 8'h81, 8'h03, 8'h00.
REQ-037 SHALL pass: 6 read pulses, tx_done_i withheld, FIFO_DEPTH=4 -> first popped, 4 queued, full_o=1, sixth dropped, ovf_o=1; all 5 frames then sent in order.
REQ-038 SHALL pass: rd_valid_i and wr_ack_i same cycle -> only read frame sent, ovf_o=1; clr_ovf_i -> ovf_o=0 next cycle.
REQ-039 SHALL pass: rst_n low after address byte start -> outputs at reset values immediately; no data byte sent after release.
REQ-040 SHALL pass: tx_done_i pulsed in S_IDLE and in a tx_start_o cycle -> no state change, no extra tx_start_o.
